// File: rtl/food_spawner_pkg.sv
// food_spawner_pkg: grid defaults, search FSM encoding and LFSR step shared by the food spawner
package food_spawner_pkg;
  localparam int FOOD_GRID_WIDTH = 40;
  localparam int FOOD_GRID_HEIGHT = 30;
  localparam int BITS_PER_FOOD_STATE = 3;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  typedef enum logic [BITS_PER_FOOD_STATE-1:0] {
    FOOD_IDLE,
    FOOD_DRAW,
    FOOD_CHECK,
    FOOD_SWEEP,
    FOOD_DONE
  } foodState_t;
  // Fibonacci taps 16,14,13,11; an all-zero result would lock up, so reseed instead
  function automatic logic [15:0] lfsrStep(input logic [15:0] v, input logic [4:0] entropy);
    logic [15:0] n;
    n = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]} ^ {11'd0, entropy};
    return (n == '0) ? LFSR_SEED : n;
  endfunction
endpackage

// File: rtl/food_spawner_lfsr.sv
// food_lfsr: free-running 16-bit LFSR stirred by button entropy; exposes its low WIDTH bits
module food_lfsr
  import food_spawner_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [4:0]       Entropy,
  output logic [WIDTH-1:0] Value
);
  logic [15:0] state;
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) state <= LFSR_SEED;
    else state <= lfsrStep(state, Entropy);
  assign Value = state[WIDTH-1:0];
endmodule

// File: rtl/food_spawner.sv
// food_spawner: picks a random free grid cell for the food, avoiding a snapshot of the snake body
module food_spawner
  import food_spawner_pkg::*;
#(
  parameter int GRID_WIDTH = FOOD_GRID_WIDTH,
  parameter int GRID_HEIGHT = FOOD_GRID_HEIGHT,
  parameter int NUM_PIECES = 4,
  parameter int MAX_TRIES = 8,
  localparam int XB = $clog2(GRID_WIDTH),
  localparam int YB = $clog2(GRID_HEIGHT),
  localparam int LB = $clog2(NUM_PIECES + 1)
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Request,
  input  logic [4:0]             Entropy,
  input  logic [NUM_PIECES*XB-1:0] SnakeXFlat,
  input  logic [NUM_PIECES*YB-1:0] SnakeYFlat,
  input  logic [LB-1:0]          SnakeLength,
  output logic [XB-1:0]          FoodX,
  output logic [YB-1:0]          FoodY,
  output logic                   FoodValid,
  output logic                   Done,
  output logic                   Busy,
  output logic                   GridFull
);
  localparam int TB = $clog2(MAX_TRIES + 1);
  localparam int CELLS = GRID_WIDTH * GRID_HEIGHT;
  localparam int SB = $clog2(CELLS + 1);
  foodState_t state;
  logic [XB+YB-1:0] lfsr;
  logic [NUM_PIECES*XB-1:0] snapX;
  logic [NUM_PIECES*YB-1:0] snapY;
  logic [LB-1:0] snapLen, idx, reqLen;
  logic [TB-1:0] tries;
  logic [SB-1:0] sweep, sweepNext;
  logic [XB-1:0] candX, drawX, nextX;
  logic [YB-1:0] candY, drawY, nextY;
  logic inRange, hit, lastPiece, xWrap;
  food_lfsr #(.WIDTH(XB + YB)) u_lfsr (
    .Clock(Clock),
    .Reset(Reset),
    .Entropy(Entropy),
    .Value(lfsr)
  );
  always_comb begin
    drawX = lfsr[XB-1:0];
    drawY = lfsr[XB+YB-1:XB];
    inRange = ({1'b0, drawX} < (XB + 1)'(GRID_WIDTH)) && ({1'b0, drawY} < (YB + 1)'(GRID_HEIGHT));
    hit = (snapX[idx*XB +: XB] == candX) && (snapY[idx*YB +: YB] == candY);
    lastPiece = idx == snapLen - 1'b1;
    xWrap = candX == XB'(GRID_WIDTH - 1);
    nextX = xWrap ? '0 : candX + 1'b1;
    nextY = !xWrap ? candY : (candY == YB'(GRID_HEIGHT - 1)) ? '0 : candY + 1'b1;
    sweepNext = sweep + 1'b1;
    reqLen = (SnakeLength == '0) ? LB'(1) : (SnakeLength > LB'(NUM_PIECES)) ? LB'(NUM_PIECES) : SnakeLength;
    Busy = state != FOOD_IDLE;
  end
  // Random draws first; after MAX_TRIES body hits fall back to a raster sweep that is bound to terminate
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      state <= FOOD_IDLE;
      FoodX <= '0;
      FoodY <= '0;
      FoodValid <= 1'b0;
      Done <= 1'b0;
      GridFull <= 1'b0;
      tries <= '0;
      sweep <= '0;
      idx <= '0;
      candX <= '0;
      candY <= '0;
      snapX <= '0;
      snapY <= '0;
      snapLen <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        FOOD_IDLE:
          if (Request) begin
            snapX <= SnakeXFlat;
            snapY <= SnakeYFlat;
            snapLen <= reqLen;
            FoodValid <= 1'b0;
            GridFull <= 1'b0;
            tries <= '0;
            sweep <= '0;
            state <= FOOD_DRAW;
          end
        FOOD_DRAW:
          if (inRange) begin
            candX <= drawX;
            candY <= drawY;
            idx <= '0;
            state <= FOOD_CHECK;
          end
        FOOD_CHECK:
          if (hit) begin
            if (tries == TB'(MAX_TRIES - 1)) state <= FOOD_SWEEP;
            else begin
              tries <= tries + 1'b1;
              state <= FOOD_DRAW;
            end
          end else if (lastPiece) begin
            FoodX <= candX;
            FoodY <= candY;
            FoodValid <= 1'b1;
            Done <= 1'b1;
            state <= FOOD_DONE;
          end else idx <= idx + 1'b1;
        FOOD_SWEEP: begin
          sweep <= sweepNext;
          if (sweepNext == SB'(CELLS)) begin
            GridFull <= 1'b1;
            FoodValid <= 1'b0;
            state <= FOOD_IDLE;
          end else begin
            candX <= nextX;
            candY <= nextY;
            idx <= '0;
            state <= FOOD_CHECK;
          end
        end
        FOOD_DONE: state <= FOOD_IDLE;
        default: state <= FOOD_IDLE;
      endcase
    end
endmodule

// File: tb/tb_food_spawner.sv
// tb_food_spawner: random food searches checked against a draw-by-draw placement model with cycle counts
module tb_food_spawner;
  logic Clock = 1'b0, Reset = 1'b0, Request = 1'b0, sRequest = 1'b0;
  logic [4:0] Entropy = '0;
  logic [23:0] SnakeXFlat = '0;
  logic [19:0] SnakeYFlat = '0;
  logic [2:0] SnakeLength = '0;
  logic [5:0] FoodX;
  logic [4:0] FoodY;
  logic FoodValid, Done, Busy, GridFull;
  logic [3:0] sSnakeXFlat = '0, sSnakeYFlat = '0;
  logic [2:0] sSnakeLength = '0;
  logic sFoodX, sFoodY, sFoodValid, sDone, sBusy, sGridFull;
  int mLfsr;
  int bx[4], by[4];
  int rawLen, blen;
  int nTests = 0, nFail = 0;

  food_spawner dut (
    .Clock(Clock), .Reset(Reset), .Request(Request), .Entropy(Entropy),
    .SnakeXFlat(SnakeXFlat), .SnakeYFlat(SnakeYFlat), .SnakeLength(SnakeLength),
    .FoodX(FoodX), .FoodY(FoodY), .FoodValid(FoodValid), .Done(Done), .Busy(Busy), .GridFull(GridFull)
  );
  food_spawner #(.GRID_WIDTH(2), .GRID_HEIGHT(2), .NUM_PIECES(4), .MAX_TRIES(1)) dutSmall (
    .Clock(Clock), .Reset(Reset), .Request(sRequest), .Entropy(Entropy),
    .SnakeXFlat(sSnakeXFlat), .SnakeYFlat(sSnakeYFlat), .SnakeLength(sSnakeLength),
    .FoodX(sFoodX), .FoodY(sFoodY), .FoodValid(sFoodValid), .Done(sDone), .Busy(sBusy), .GridFull(sGridFull)
  );

  always #5 Clock = ~Clock;

  function automatic int lfsrRef(input int v, input int e);
    int n;
    n = (((v << 1) & 'hFFFF) | (((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1)) ^ e;
    return n == 0 ? 'hACE1 : n;
  endfunction

  always @(posedge Clock or posedge Reset) mLfsr <= Reset ? 'hACE1 : lfsrRef(mLfsr, int'(Entropy));

  function automatic int firstHit(input int x, input int y);
    for (int j = 0; j < blen; j++) if (bx[j] == x && by[j] == y) return j;
    return -1;
  endfunction

  // Walks the draws one cycle at a time: DRAW costs 1, each piece compared costs 1, placement costs 1
  function automatic void predict(input int w, h, mt, xb, yb, l0, e, output int fx, fy, full, tEnd);
    int lf, t, tries, x, y, j;
    lf = l0; t = 1; tries = 0;
    fx = 0; fy = 0; full = 0; tEnd = 0;
    while (1) begin
      x = lf % (1 << xb);
      y = (lf >> xb) % (1 << yb);
      lf = lfsrRef(lf, e);
      t++;
      if (x >= w || y >= h) continue;
      j = firstHit(x, y);
      if (j < 0) begin fx = x; fy = y; tEnd = t + blen; return; end
      for (int k = 0; k <= j; k++) lf = lfsrRef(lf, e);
      t += j + 1;
      if (tries < mt - 1) begin tries++; continue; end
      for (int s = 1; s < w * h; s++) begin
        x++;
        if (x == w) begin x = 0; y = (y + 1) % h; end
        t++;
        j = firstHit(x, y);
        if (j < 0) begin fx = x; fy = y; tEnd = t + blen; return; end
        t += j + 1;
      end
      full = 1; tEnd = t + 1;
      return;
    end
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyBody();
    for (int i = 0; i < 4; i++) begin
      SnakeXFlat[i*6 +: 6] = 6'(bx[i]);
      SnakeYFlat[i*5 +: 5] = 5'(by[i]);
      sSnakeXFlat[i] = 1'(bx[i] & 1);
      sSnakeYFlat[i] = 1'(by[i] & 1);
    end
    SnakeLength = 3'(rawLen);
    sSnakeLength = 3'(rawLen);
    blen = rawLen == 0 ? 1 : rawLen > 4 ? 4 : rawLen;
  endtask

  task automatic randomBody(input int len);
    rawLen = len;
    for (int i = 0; i < 4; i++) begin
      bx[i] = $urandom_range(0, 39);
      by[i] = $urandom_range(0, 29);
    end
  endtask

  task automatic doSearch(input bit isSmall, input bit disturb, input bit trap);
    int w, h, e, l, fx, fy, full, tEnd, c, gx, gy;
    bit ended;
    w = isSmall ? 2 : 40;
    h = isSmall ? 2 : 30;
    @(negedge Clock);
    e = $urandom_range(0, 31);
    Entropy = 5'(e);
    if (trap) begin
      l = lfsrRef(mLfsr, e);
      while (l % 64 >= 40 || (l >> 6) % 32 >= 30) l = lfsrRef(l, e);
      bx[2] = l % 64;
      by[2] = (l >> 6) % 32;
      for (int i = 0; i < 4; i++)
        if (i != 2 && bx[i] == bx[2] && by[i] == by[2]) bx[i] = (bx[2] + 1) % 40;
    end
    applyBody();
    if (isSmall) sRequest = 1'b1; else Request = 1'b1;
    @(posedge Clock); #1;
    Request = 1'b0;
    sRequest = 1'b0;
    predict(w, h, isSmall ? 1 : 8, isSmall ? 1 : 6, isSmall ? 1 : 5, mLfsr, e, fx, fy, full, tEnd);
    c = 1;
    ended = 1'b0;
    while (!ended && c < 8000) begin
      ended = isSmall ? (sDone || (sGridFull && !sBusy)) : (Done || (GridFull && !Busy));
      if (!ended) begin
        if (disturb) begin
          Request = Busy & 1'($urandom);
          SnakeXFlat = 24'($urandom);
        end
        @(posedge Clock); #1;
        c++;
      end
    end
    gx = isSmall ? int'(sFoodX) : int'(FoodX);
    gy = isSmall ? int'(sFoodY) : int'(FoodY);
    check("latency", c, tEnd);
    check("gridFull", isSmall ? int'(sGridFull) : int'(GridFull), full);
    check("foodValid", isSmall ? int'(sFoodValid) : int'(FoodValid), full ? 0 : 1);
    check("busyAtEnd", isSmall ? int'(sBusy) : int'(Busy), full ? 0 : 1);
    if (full == 0) begin
      check("foodX", gx, fx);
      check("foodY", gy, fy);
      check("doneRise", isSmall ? int'(sDone) : int'(Done), 1);
      check("offBody", firstHit(gx, gy) < 0 ? 1 : 0, 1);
      check("inGrid", (gx < w && gy < h) ? 1 : 0, 1);
    end
    if (disturb && full == 0) Request = 1'b1;
    @(posedge Clock); #1;
    Request = 1'b0;
    check("donePulse", isSmall ? int'(sDone) : int'(Done), 0);
    check("idleAfter", isSmall ? int'(sBusy) : int'(Busy), 0);
    if (full == 0) begin
      check("holdX", isSmall ? int'(sFoodX) : int'(FoodX), fx);
      check("holdValid", isSmall ? int'(sFoodValid) : int'(FoodValid), 1);
    end
  endtask

  initial begin
    #1 Reset = 1'b1;
    #1;
    check("rstBusy", Busy, 0);
    check("rstValid", FoodValid, 0);
    check("rstDone", Done, 0);
    check("rstFull", GridFull, 0);
    check("rstX", FoodX, 0);
    check("rstY", FoodY, 0);
    @(negedge Clock);
    Reset = 1'b0;
    bx = '{1, 0, 0, 0};
    by = '{1, 0, 0, 0};
    rawLen = 1;
    doSearch(1'b0, 1'b0, 1'b0);
    randomBody(4);
    doSearch(1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 25; n++) begin
      randomBody($urandom_range(0, 7));
      doSearch(1'b0, n % 3 == 0, 1'b0);
    end
    for (int n = 0; n < 4; n++) begin
      bx = '{0, 1, 0, 1};
      by = '{0, 0, 1, 1};
      rawLen = 3;
      doSearch(1'b1, 1'b0, 1'b0);
      check("sweepCell", {sFoodX, sFoodY}, 3);
    end
    rawLen = 4;
    doSearch(1'b1, 1'b0, 1'b0);
    check("fullSticky", sGridFull, 1);
    @(negedge Clock);
    randomBody(4);
    applyBody();
    Request = 1'b1;
    @(posedge Clock); #1;
    Request = 1'b0;
    @(posedge Clock);
    @(posedge Clock);
    #3 Reset = 1'b1;
    #1;
    check("midBusy", Busy, 0);
    check("midValid", FoodValid, 0);
    check("midDone", Done, 0);
    check("midFull", GridFull, 0);
    check("midX", FoodX, 0);
    check("midY", FoodY, 0);
    @(negedge Clock);
    Reset = 1'b0;
    randomBody(3);
    doSearch(1'b0, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
